// File: rtl/addsub_serial_pkg.sv
// Shared ALU definitions for the serial add/subtract unit:
// op encodings, status bit positions and FSM state codes.
package addsub_serial_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBC = 2'b11;

   localparam int ST_N = 3;
   localparam int ST_Z = 2;
   localparam int ST_C = 1;
   localparam int ST_V = 0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic is_sub(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SBC);
   endfunction

   // Carry-in seed: SUB forces 1, ADC/SBC take the stored carry.
   function automatic logic op_cin(input logic [1:0] op, input logic cflag);
      logic c;
      case (op)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cflag;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder; also exposes the carry into its top bit
// so the caller can derive two's-complement overflow on the last chunk.
module addsub_chunk
   import addsub_serial_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   generate
      if (CHUNK == 1) begin : g_one
         assign c_msb = cin;
      end else begin : g_wide
         logic [CHUNK-2:0] low;
         assign {c_msb, low} = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]}
                             + {{(CHUNK-1){1'b0}}, cin};
         assign sum[CHUNK-2:0] = low;
      end
   endgenerate

   assign sum[CHUNK-1] = a[CHUNK-1] ^ b[CHUNK-1] ^ c_msb;
   assign cout = (a[CHUNK-1] & b[CHUNK-1]) | (c_msb & (a[CHUNK-1] ^ b[CHUNK-1]));

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, with
// a persistent carry flag for ADC/SBC chaining across words.
module addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       statusOut,
   output logic             carry_flag
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = $clog2(NCH + 1);
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa, opb;
   logic             cin_q;
   logic             z_acc;
   logic [CHUNK-1:0] sum;
   logic             cout, c_msb;
   logic [WIDTH-1:0] result_nxt;
   logic             sum_zero;

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (opa[CHUNK-1:0]),
      .b     (opb[CHUNK-1:0]),
      .cin   (cin_q),
      .sum   (sum),
      .cout  (cout),
      .c_msb (c_msb)
   );

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign sum_zero  = ~|sum;

   // Merge the current chunk into its slot without a variable-index select.
   always_comb begin
      result_nxt = result;
      for (int i = 0; i < NCH; i++) begin
         if (cnt == CW'(i)) result_nxt[i*CHUNK +: CHUNK] = sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         opa        <= '0;
         opb        <= '0;
         cin_q      <= 1'b0;
         z_acc      <= 1'b0;
         result     <= '0;
         statusOut  <= '0;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  opa   <= operand1;
                  opb   <= is_sub(op) ? ~operand2 : operand2;
                  cin_q <= op_cin(op, carry_flag);
                  cnt   <= '0;
                  z_acc <= 1'b1;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // Operands shift down so the adder always sees the low chunk.
               result <= result_nxt;
               opa    <= opa >> CHUNK;
               opb    <= opb >> CHUNK;
               cin_q  <= cout;
               z_acc  <= z_acc & sum_zero;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  statusOut[ST_N] <= sum[CHUNK-1];
                  statusOut[ST_Z] <= z_acc & sum_zero;
                  statusOut[ST_C] <= cout;
                  statusOut[ST_V] <= cout ^ c_msb;
                  carry_flag      <= cout;
                  state           <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial at WIDTH=16, CHUNK=4: arithmetic and
// flags, ADC/SBC chaining, backpressure in DONE and reset mid-operation.
module tb_addsub_serial;
   import addsub_serial_pkg::*;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] operand1 = '0;
   logic [WIDTH-1:0] operand2 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [3:0]       statusOut;
   logic             carry_flag;

   int tests = 0;
   int fails = 0;

   addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .operand1   (operand1),
      .operand2   (operand2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .statusOut  (statusOut),
      .carry_flag (carry_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request on a negedge, hold it through the accept edge, then scramble inputs.
   task automatic issue(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; op = o; operand1 = a; operand2 = b;
      @(posedge clk); #1;
      in_valid = 1'b0; op = ~o; operand1 = 16'hdead; operand2 = 16'hbeef;
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 32'd4);
   endtask

   task automatic check_res(input string tag, input logic [15:0] er, input logic [3:0] es, input logic ec);
      chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
      chk({tag, "_status"}, {28'd0, statusOut}, {28'd0, es});
      chk({tag, "_carry"},  {31'd0, carry_flag}, {31'd0, ec});
      chk({tag, "_busy_rdy"}, {31'd0, in_ready}, 32'd0);
   endtask

   task automatic complete(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [3:0] es, input logic ec);
      issue(tag, o, a, b);
      wait_done(tag);
      check_res(tag, er, es, ec);
      complete(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
      chk("rst_out_valid", {31'd0, out_valid},  32'd0);
      chk("rst_result",    {16'd0, result},     32'd0);
      chk("rst_status",    {28'd0, statusOut},  32'd0);
      chk("rst_carry",     {31'd0, carry_flag}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_op("sub_pos",  OP_SUB, 16'h0005, 16'h0003, 16'h0002, 4'b0010, 1'b1);
      run_op("sub_neg",  OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 1'b0);
      run_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0);
      run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b1);
      run_op("adc",      OP_ADC, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0);
      run_op("sub_lo",   OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 1'b0);
      run_op("sbc_hi",   OP_SBC, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 1'b1);

      // Hold DONE under backpressure while poking in_valid with another request.
      issue("bp", OP_ADD, 16'h1234, 16'h1111);
      wait_done("bp");
      check_res("bp", 16'h2345, 4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op = OP_SUB; operand1 = 16'hFFFF; operand2 = 16'h0001;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("bp_out_valid", {31'd0, out_valid},  32'd1);
         chk("bp_result",    {16'd0, result},     32'h2345);
         chk("bp_status",    {28'd0, statusOut},  32'd0);
         chk("bp_in_ready",  {31'd0, in_ready},   32'd0);
      end
      complete("bp");

      // Leave carry_flag set, then reset two cycles into a SUB.
      run_op("pre_rst", OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 4'b0010, 1'b1);
      issue("rst_mid", OP_SUB, 16'h0009, 16'h0001);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  {31'd0, in_ready},   32'd1);
      chk("mid_rst_out_valid", {31'd0, out_valid},  32'd0);
      chk("mid_rst_result",    {16'd0, result},     32'd0);
      chk("mid_rst_status",    {28'd0, statusOut},  32'd0);
      chk("mid_rst_carry",     {31'd0, carry_flag}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst_adc", OP_ADC, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
